// File: rtl/alu_writeback.sv
// ALU writeback stage: flag merge into the SC register plus a 2-entry skid queue
// for lane-aligned register-file writes.
module alu_writeback #(
    parameter logic [7:0] SC_RESET = 8'hC0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] alu_R,
    input  logic [3:0]  alu_flags,
    input  logic        alu_size,
    input  logic [3:0]  flag_mask,
    input  logic        wr_reg,
    input  logic [3:0]  dest_sel,
    input  logic        dest_hi,
    input  logic        sc_load,
    input  logic [7:0]  sc_load_value,
    output logic [7:0]  sc,
    output logic        carry_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_byte_en,
    output logic [3:0]  out_dest
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e      state_q;
    logic [7:0]  sc_q;
    logic        in_ready_q;
    logic        o_valid_q;
    logic [15:0] o_data_q;
    logic [1:0]  o_be_q;
    logic [3:0]  o_dest_q;
    logic [15:0] k_data_q;
    logic [1:0]  k_be_q;
    logic [3:0]  k_dest_q;

    logic        accept;
    logic        push;
    logic        drain;
    logic [15:0] new_data;
    logic [1:0]  new_be;
    logic [7:0]  sc_d;

    assign accept = in_valid & in_ready_q;
    assign push   = accept & wr_reg;
    assign drain  = o_valid_q & out_ready;

    always_comb begin
        new_data = alu_R;
        new_be   = 2'b11;
        if (!alu_size) begin
            if (dest_hi) begin
                new_data = {alu_R[7:0], 8'h00};
                new_be   = 2'b10;
            end else begin
                new_data = {8'h00, alu_R[7:0]};
                new_be   = 2'b01;
            end
        end
    end

    // A direct SC load wins over the accepted op's flags.
    always_comb begin
        sc_d = sc_q;
        if (accept) begin
            if (sc_load) begin
                sc_d = sc_load_value;
            end else begin
                sc_d[3:0] = (sc_q[3:0] & ~flag_mask) | (alu_flags & flag_mask);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StEmpty;
            sc_q       <= SC_RESET;
            in_ready_q <= 1'b1;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_be_q     <= '0;
            o_dest_q   <= '0;
            k_data_q   <= '0;
            k_be_q     <= '0;
            k_dest_q   <= '0;
        end else begin
            sc_q <= sc_d;
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        o_valid_q <= 1'b1;
                        o_data_q  <= new_data;
                        o_be_q    <= new_be;
                        o_dest_q  <= dest_sel;
                        state_q   <= StOne;
                    end
                end
                StOne: begin
                    if (push && !drain) begin
                        k_data_q   <= new_data;
                        k_be_q     <= new_be;
                        k_dest_q   <= dest_sel;
                        in_ready_q <= 1'b0;
                        state_q    <= StFull;
                    end else if (push && drain) begin
                        o_data_q <= new_data;
                        o_be_q   <= new_be;
                        o_dest_q <= dest_sel;
                    end else if (drain) begin
                        o_valid_q <= 1'b0;
                        state_q   <= StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        o_data_q   <= k_data_q;
                        o_be_q     <= k_be_q;
                        o_dest_q   <= k_dest_q;
                        in_ready_q <= 1'b1;
                        state_q    <= StOne;
                    end
                end
                default: begin
                    state_q   <= StEmpty;
                    o_valid_q <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign sc          = sc_q;
    assign carry_out   = sc_q[1];
    assign out_valid   = o_valid_q;
    assign out_data    = o_data_q;
    assign out_byte_en = o_be_q;
    assign out_dest    = o_dest_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus random traffic against a queue model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_R;
    logic [3:0]  alu_flags;
    logic        alu_size;
    logic [3:0]  flag_mask;
    logic        wr_reg;
    logic [3:0]  dest_sel;
    logic        dest_hi;
    logic        sc_load;
    logic [7:0]  sc_load_value;
    logic [7:0]  sc;
    logic        carry_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_byte_en;
    logic [3:0]  out_dest;

    alu_writeback #(.SC_RESET(8'hC0)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_R        (alu_R),
        .alu_flags    (alu_flags),
        .alu_size     (alu_size),
        .flag_mask    (flag_mask),
        .wr_reg       (wr_reg),
        .dest_sel     (dest_sel),
        .dest_hi      (dest_hi),
        .sc_load      (sc_load),
        .sc_load_value(sc_load_value),
        .sc           (sc),
        .carry_out    (carry_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_byte_en  (out_byte_en),
        .out_dest     (out_dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  be;
        logic [3:0]  dest;
    } wr_t;

    wr_t        m_q[$];
    logic [7:0] m_sc;
    int         errors = 0;
    int         checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("sc", {24'h0, sc}, {24'h0, m_sc});
        check_eq("carry_out", {31'h0, carry_out}, {31'h0, m_sc[1]});
        check_eq("in_ready", {31'h0, in_ready}, {31'h0, m_q.size() < 2});
        check_eq("out_valid", {31'h0, out_valid}, {31'h0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check_eq("out_data", {16'h0, out_data}, {16'h0, m_q[0].data});
            check_eq("out_byte_en", {30'h0, out_byte_en}, {30'h0, m_q[0].be});
            check_eq("out_dest", {28'h0, out_dest}, {28'h0, m_q[0].dest});
        end
    endtask

    // Called away from the rising edge; advances one clock and updates the model.
    task automatic tick();
        bit  acc;
        bit  drn;
        wr_t e;
        acc = in_valid && (m_q.size() < 2);
        drn = (m_q.size() != 0) && out_ready;
        e.data = alu_size ? alu_R : (dest_hi ? (alu_R << 8) : (alu_R & 16'h00FF));
        e.be   = alu_size ? 2'b11 : (dest_hi ? 2'b10 : 2'b01);
        e.dest = dest_sel;
        @(posedge clk);
        if (drn) void'(m_q.pop_front());
        if (acc) begin
            if (sc_load) begin
                m_sc = sc_load_value;
            end else begin
                for (int i = 0; i < 4; i++) if (flag_mask[i]) m_sc[i] = alu_flags[i];
            end
            if (wr_reg) m_q.push_back(e);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_op(input logic v, input logic [15:0] r, input logic [3:0] fl,
                          input logic [3:0] mk, input logic sz, input logic hi,
                          input logic wr, input logic [3:0] d);
        in_valid  = v;
        alu_R     = r;
        alu_flags = fl;
        flag_mask = mk;
        alu_size  = sz;
        dest_hi   = hi;
        wr_reg    = wr;
        dest_sel  = d;
        sc_load   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_op(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        sc_load_value = 8'h00;
        out_ready = 1'b0;
        m_sc = 8'hC0;
        repeat (2) @(negedge clk);
        check_eq("rst_sc", {24'h0, sc}, 32'hC0);
        check_eq("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check_eq("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_out_data", {16'h0, out_data}, 32'h0);
        check_eq("rst_out_be", {30'h0, out_byte_en}, 32'h0);
        check_eq("rst_out_dest", {28'h0, out_dest}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check_outputs();

        // Carry chain
        out_ready = 1'b1;
        set_op(1'b1, 16'h0001, 4'b0010, 4'b1111, 1'b1, 1'b0, 1'b1, 4'h1);
        tick();
        check_eq("add_sc", {24'h0, sc}, 32'hC2);
        check_eq("add_carry", {31'h0, carry_out}, 32'h1);
        set_op(1'b1, 16'h0002, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1, 4'h1);
        tick();
        check_eq("adc_sc", {24'h0, sc}, 32'hC0);

        // Byte lanes
        set_op(1'b1, 16'h12AB, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2);
        tick();
        check_eq("lane_lo_data", {16'h0, out_data}, 32'h00AB);
        check_eq("lane_lo_be", {30'h0, out_byte_en}, 32'h1);
        set_op(1'b1, 16'h12AB, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h2);
        tick();
        check_eq("lane_hi_data", {16'h0, out_data}, 32'hAB00);
        check_eq("lane_hi_be", {30'h0, out_byte_en}, 32'h2);
        set_op(1'b1, 16'h12AB, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2);
        tick();
        check_eq("lane_w_data", {16'h0, out_data}, 32'h12AB);
        check_eq("lane_w_be", {30'h0, out_byte_en}, 32'h3);
        set_op(1'b0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();

        // Backpressure: W1, W2 absorbed, W3 held off, then ordered drain
        out_ready = 1'b0;
        set_op(1'b1, 16'h1111, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3);
        tick();
        set_op(1'b1, 16'h2222, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4);
        tick();
        check_eq("bp_in_ready", {31'h0, in_ready}, 32'h0);
        set_op(1'b1, 16'h3333, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h5);
        tick();
        check_eq("bp_hold_data", {16'h0, out_data}, 32'h1111);
        out_ready = 1'b1;
        tick();
        check_eq("bp_drain2", {16'h0, out_data}, 32'h2222);
        tick();
        check_eq("bp_drain3", {16'h0, out_data}, 32'h3333);
        set_op(1'b0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        check_eq("bp_empty", {31'h0, out_valid}, 32'h0);

        // Collision: SC load beats flags, write still queued
        out_ready = 1'b0;
        set_op(1'b1, 16'h5A5A, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 4'h6);
        sc_load = 1'b1;
        sc_load_value = 8'h35;
        tick();
        check_eq("coll_sc", {24'h0, sc}, 32'h35);
        check_eq("coll_valid", {31'h0, out_valid}, 32'h1);

        // Fill, release FULL, then flags-only op while stalled
        set_op(1'b1, 16'h7777, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h7);
        tick();
        out_ready = 1'b1;
        set_op(1'b0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        out_ready = 1'b0;
        set_op(1'b1, 16'hFFFF, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, 4'h8);
        tick();
        check_eq("cp_sc0", {31'h0, sc[0]}, 32'h1);
        check_eq("cp_occ_data", {16'h0, out_data}, 32'h7777);
        check_eq("cp_in_ready", {31'h0, in_ready}, 32'h1);

        // Async reset mid-transfer
        set_op(1'b1, 16'h4444, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h9);
        tick();
        reset = 1'b1;
        #1;
        check_eq("arst_sc", {24'h0, sc}, 32'hC0);
        check_eq("arst_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("arst_in_ready", {31'h0, in_ready}, 32'h1);
        m_q.delete();
        m_sc = 8'hC0;
        set_op(1'b0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("arst_dropped", {31'h0, out_valid}, 32'h0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            alu_R         = 16'($urandom);
            alu_flags     = 4'($urandom);
            flag_mask     = 4'($urandom);
            alu_size      = 1'($urandom);
            dest_hi       = 1'($urandom);
            wr_reg        = ($urandom_range(0, 4) != 0);
            dest_sel      = 4'($urandom);
            sc_load       = ($urandom_range(0, 9) == 0);
            sc_load_value = 8'($urandom);
            out_ready     = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the CPU ALU. Captures each ALU result and its 4-bit flag vector.
- Updates the architectural SC (status/condition) register under a per-flag write mask.
- Queues the byte/word register-file write in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Feeds SC[1] (carry) back to the ALU C input so back-to-back ADC/SBC/RL/RR chains see the updated carry.

Parameters:
- SC_RESET, 8'hC0, SC value after reset. Bits: Z=0, C=1, V=2, S=3, D=4, U=5, I0=6, I1=7. Reset masks interrupts.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  decoder/ALU presents an operation this cycle
- in_ready  output  1  stage can accept; driven from a register
- alu_R  input  16  ALU result
- alu_flags  input  4  ALU flags {S,V,C,Z}, bit order as in SC[3:0]
- alu_size  input  1  1=word, 0=byte
- flag_mask  input  4  per-flag update enable, aligned to SC[3:0]
- wr_reg  input  1  1=operation writes a register; 0=flags only (CP, BIT)
- dest_sel  input  4  destination register index
- dest_hi  input  1  byte op targets the high byte of dest_sel
- sc_load  input  1  direct SC load (POP SC, LD SC,#nn, AND/OR SC)
- sc_load_value  input  8  value for sc_load
- sc  output  8  architectural SC register
- carry_out  output  1  equals sc[1], wired to ALU C
- out_valid  output  1  register-file write pending
- out_ready  input  1  register file accepts write
- out_data  output  16  write data, already lane-aligned
- out_byte_en  output  2  {hi,lo} byte enables
- out_dest  output  4  register index

Behaviour:
- Reset (async, asserted): sc=SC_RESET, in_ready=1, out_valid=0, out_data=0, out_byte_en=0, out_dest=0, skid entry invalid, occupancy=0.
- Reset deasserting mid-operation: all queued writes are dropped. Nothing is replayed.
- accept = in_valid & in_ready. A flags-only op (wr_reg=0) also requires in_ready but consumes no entry.
- Flag update happens on the accept edge, not at drain. For each i in 0..3 with flag_mask[i]=1, sc[i]<=alu_flags[i]. Masked-off bits and bits 7:4 are held.
  - Latency: sc is visible the cycle after accept. carry_out is combinationally sc[1].
- sc_load and accept in the same cycle: sc<=sc_load_value for all 8 bits. The accepted op's flags are discarded. Its register write is still enqueued.
- Lane formatting, computed at accept:
  - alu_size=1: data=alu_R, be=2'b11. dest_hi is ignored.
  - alu_size=0, dest_hi=0: data={8'h00,alu_R[7:0]}, be=2'b01.
  - alu_size=0, dest_hi=1: data={alu_R[7:0],8'h00}, be=2'b10.
- Queue: an output register (O) plus a skid entry (K). occupancy is 0..2.
  - States: EMPTY (occ 0), ONE (O valid), FULL (O and K valid).
  - EMPTY: an accepted write loads O and goes to ONE.
  - ONE:
    - accept without drain: load K, go to FULL, in_ready<=0 next cycle.
    - drain without accept: go to EMPTY.
    - accept and drain together: O<=new entry, stay ONE.
  - FULL: in_ready=0. On drain, O<=K, go to ONE, in_ready<=1 next cycle.
  - drain = out_valid & out_ready.
- Ordering: writes drain strictly in accept order. Flags-only ops never create a bubble or entry.
- out_* outputs are stable while out_valid=1 and out_ready=0.
- in_ready is a register: in_ready=1 iff K is invalid. This guarantees no combinational in_ready/out_ready path.
- Throughput: 1 op/cycle when out_ready is held 1. Up to 2 writes are absorbed during a register-file stall.

Test Plan:
- Reset check: assert reset mid-transfer -> sc=8'hC0, out_valid=0, in_ready=1 immediately (async). Queued writes are lost after release.
- Carry chain: sc=8'hC0; accept ADD with alu_flags=4'b0010, mask=4'b1111 -> next cycle sc=8'hC2 and carry_out=1. Then accept ADC with flags=0, mask=4'b0010 -> sc=8'hC0.
- Byte lanes: alu_R=16'h12AB in three accepts, checking out_data/out_byte_en:
  - size=0, dest_hi=0 -> 16'h00AB/2'b01.
  - size=0, dest_hi=1 -> 16'hAB00/2'b10.
  - size=1 -> 16'h12AB/2'b11.
- Backpressure: out_ready=0, accept writes W1,W2 -> in_ready=0 the cycle after W2, W3 is held off. Raise out_ready -> W1,W2,W3 drain in order with no loss or duplicate.
- Collision: sc_load=1 with sc_load_value=8'h35 plus accept with flags=4'b1111, mask=4'b1111 -> sc=8'h35, and the write is still enqueued.
- Flags-only: wr_reg=0 CP with flags=4'b0001, mask=4'b1111 while FULL is released -> sc[0]=1, occupancy unchanged, no out transfer generated.
